multicycle_controller: RTL and testbench
========================================

# multicycle_controller

- Hardwired Moore control sequencer for the multicycle CPU datapath.
- Runs fetch, decode and execute for the 16-bit instruction set.
- Drives every datapath tri-state enable, load strobe, mux select, ALU function code and memory strobe from a one-hot-per-state decode of a 5-bit state register.
- Sits between the datapath (opcode, function field and condition in; controls out) and external memory (`mem_ready` handshake).

## Interface
Parameters:
- `SP_EN_DEFAULT`, 1: informational only; stack support is selected by macro (see Configuration).

Ports:
- `clk` in 1: rising-edge state clock. The datapath loads registers on the falling edge, mid-state.
- `reset` in 1: synchronous, active-high.
- `ir1` in 4: opcode from the IR.
- `ir2` in 3: ALU function field from the IR.
- `dcond` in 1: selected condition from the status selector.
- `mem_ready` in 1: memory has completed the current `memrd`/`memwr`.
- `tmar`, `ldmar`, `tmdr`, `ldmdr`, `memwr`, `memrd`, `rd`, `wr`, `tsp`, `ldsp`, `tpc`, `ldpc`, `ldt`, `tir`, `ldir` out 1 each: datapath strobes.
- `m1` out 1: 1 selects `ir2` as the ALU function; 0 selects `fnotsel_cont`.
- `m2` out 1: MDR input select; 0 selects Dbusin, 1 selects zbus.
- `fnotsel_cont` out 3: ALU code. 000 add, 001 neg, 010 or, 011 not, 100 inc, 101 dec, 110 pass X, 111 pass Y.
- `halted` out 1: high in HALT.
- `illegal` out 1: one-cycle pulse on an unsupported opcode.
- `state_o` out 5: current state, for debug.

## Operation
- Reset state RST: all outputs 0, `fnotsel_cont`=000.
- Fetch and decode states:
  - RST → F0.
  - F0: MAR←PC. Asserts `tpc`, fn 110, `ldmar`.
  - F1: IR←M[MAR]. Asserts `tmar`, `memrd`, `ldir`. Holds until `mem_ready`.
  - F2: PC←PC+1. Asserts `tpc`, fn 100, `ldpc`.
  - DEC: all strobes 0. Branches on `ir1`.
- Opcodes:
  - 0000–1000: conditional jump.
    - BR0 asserts `tir`, fn 110, and `ldpc` = `dcond`.
    - Status codes: 0000 always, 0001 C, 0010 NC, 0011 Z, 0100 NZ, 0101 V, 0110 NV, 0111 S, 1000 NS.
  - 1001 ALU: ALU0 = `rd`, `m1`=1, `wr`. Computes R[ir3]←f(R[ir3],T).
  - 1010 LDT: LDT0 = `rd`, fn 110, `ldt`.
  - 1011 LOAD:
    - LD0: MAR←R. Asserts `rd`, fn 110, `ldmar`.
    - LD1: MDR←M. Asserts `tmar`, `memrd`, `m2`=0, `ldmdr`. Waits for `mem_ready`.
    - LD2: R←MDR. Asserts `tmdr`, fn 110, `wr`.
  - 1100 STORE:
    - ST0: MAR←T. Asserts fn 111, `ldmar`.
    - ST1: MDR←R. Asserts `rd`, fn 110, `m2`=1, `ldmdr`.
    - ST2: asserts `tmar`, `memwr`. Waits for `mem_ready`.
  - 1101 PUSH:
    - PU0: SP←SP−1. Asserts `tsp`, fn 101, `ldsp`.
    - PU1: MAR←SP.
    - PU2: MDR←R, `m2`=1.
    - PU3: write, waits for `mem_ready`.
  - 1110 POP:
    - PO0: MAR←SP.
    - PO1: read into MDR, waits for `mem_ready`.
    - PO2: R←MDR.
    - PO3: SP←SP+1. Asserts `tsp`, fn 100, `ldsp`.
  - 1111 HALT: stays in HALT until `reset`. All strobes 0.
- Every last execute state → F0.
- At most one of `tsp`/`tpc`/`tmdr`/`tir`/`rd` is high in any state.
- `ldX` and `memwr` are never asserted together with `reset`.

## Timing
- One state per clock, except F1, LD1, ST2, PU3 and PO1.
  - These hold while `mem_ready`=0 at the rising edge.
  - They advance on the first edge with `mem_ready`=1.
  - `mem_ready` already high on entry gives 1 cycle.
- Strobes in a wait state stay asserted for the whole wait.
- `ldir` and `ldmdr` stay asserted during the wait. The final falling-edge load captures valid data.
- Zero-wait cycle counts:
  - Fetch+decode: 4.
  - Per instruction: BR 5, ALU 5, LDT 5, LOAD 7, STORE 7, PUSH/POP 8.
- `reset` high at any edge, including mid-wait, forces RST on the next cycle. Outputs are 0 from then on.
- `illegal` is high during the DEC cycle only.

## Configuration
- `CTRL_STACK_EN` defined: PUSH/POP are implemented as above.
- `CTRL_STACK_EN` undefined:
  - Opcodes 1101/1110 pulse `illegal` in DEC and go DEC→F0.
  - PC has already been incremented, so these opcodes behave as a NOP.
  - PU*/PO* states are absent and their encodings are unreachable.
  - `tsp`/`ldsp` are tied 0.

## Structure
- Package `cpu_ctrl_pkg` holds:
  - state encoding constants;
  - opcode constants;
  - ALU function codes 000–111;
  - condition-code names.
- One sub-module `ctrl_decode`: pure combinational state→strobe decode.
- The top level holds the state register and the next-state logic.

## Test plan
- Reset held for 3 cycles with random inputs: all outputs 0, `state_o`=RST. On release, the next state is F0 with `tpc`=`ldmar`=1, fn 110.
- Fetch with `mem_ready` low for 2 cycles: `memrd`+`tmar`+`ldir` high for exactly 3 cycles, then F2 with `ldpc`=1, fn 100.
- `ir1`=0011, `dcond`=0 → BR0 with `ldpc`=0. With `dcond`=1 → `ldpc`=1 and `tir`=1. Both return to F0 after 5 cycles.
- LOAD with `mem_ready`=1: state sequence F0,F1,F2,DEC,LD0,LD1,LD2,F0. In LD1, `m2`=0 and `ldmdr`=1. In LD2, `tmdr`=`wr`=1.
- PUSH with `CTRL_STACK_EN` defined: PU0 shows `tsp`, `ldsp`, fn 101. Without the macro, `illegal` pulses once and the next state is F0.
- `reset` asserted during ST2 with `mem_ready`=0: `memwr` drops on the next cycle. `ir1`=1111 → `halted`=1 and remains so for 20 cycles.

Source files
------------

// File: rtl/multicycle_controller_pkg.sv
// Shared definitions for the multicycle CPU control sequencer: state
// encoding, opcodes, ALU function codes, condition codes and the control word.
// The PU*/PO* encodings are always declared here; whether they are reachable
// depends on CTRL_STACK_EN in the sequencer.
package cpu_ctrl_pkg;

   typedef enum logic [4:0] {
      S_RST  = 5'd0,
      S_F0   = 5'd1,
      S_F1   = 5'd2,
      S_F2   = 5'd3,
      S_DEC  = 5'd4,
      S_BR0  = 5'd5,
      S_ALU0 = 5'd6,
      S_LDT0 = 5'd7,
      S_LD0  = 5'd8,
      S_LD1  = 5'd9,
      S_LD2  = 5'd10,
      S_ST0  = 5'd11,
      S_ST1  = 5'd12,
      S_ST2  = 5'd13,
      S_PU0  = 5'd14,
      S_PU1  = 5'd15,
      S_PU2  = 5'd16,
      S_PU3  = 5'd17,
      S_PO0  = 5'd18,
      S_PO1  = 5'd19,
      S_PO2  = 5'd20,
      S_PO3  = 5'd21,
      S_HALT = 5'd22
   } state_t;

   // Condition codes carried in ir1 for the conditional jumps
   localparam logic [3:0] CC_ALWAYS = 4'b0000;
   localparam logic [3:0] CC_C      = 4'b0001;
   localparam logic [3:0] CC_NC     = 4'b0010;
   localparam logic [3:0] CC_Z      = 4'b0011;
   localparam logic [3:0] CC_NZ     = 4'b0100;
   localparam logic [3:0] CC_V      = 4'b0101;
   localparam logic [3:0] CC_NV     = 4'b0110;
   localparam logic [3:0] CC_S      = 4'b0111;
   localparam logic [3:0] CC_NS     = 4'b1000;

   // Opcodes above the last condition code
   localparam logic [3:0] OP_BR_LAST = CC_NS;
   localparam logic [3:0] OP_ALU     = 4'b1001;
   localparam logic [3:0] OP_LDT     = 4'b1010;
   localparam logic [3:0] OP_LOAD    = 4'b1011;
   localparam logic [3:0] OP_STORE   = 4'b1100;
   localparam logic [3:0] OP_PUSH    = 4'b1101;
   localparam logic [3:0] OP_POP     = 4'b1110;
   localparam logic [3:0] OP_HALT    = 4'b1111;

   // ALU function codes driven on fnotsel_cont
   localparam logic [2:0] FN_ADD   = 3'b000;
   localparam logic [2:0] FN_NEG   = 3'b001;
   localparam logic [2:0] FN_OR    = 3'b010;
   localparam logic [2:0] FN_NOT   = 3'b011;
   localparam logic [2:0] FN_INC   = 3'b100;
   localparam logic [2:0] FN_DEC   = 3'b101;
   localparam logic [2:0] FN_PASSX = 3'b110;
   localparam logic [2:0] FN_PASSY = 3'b111;

   typedef struct packed {
      logic       tmar;
      logic       ldmar;
      logic       tmdr;
      logic       ldmdr;
      logic       memwr;
      logic       memrd;
      logic       rd;
      logic       wr;
      logic       tsp;
      logic       ldsp;
      logic       tpc;
      logic       ldpc;
      logic       ldt;
      logic       tir;
      logic       ldir;
      logic       m1;
      logic       m2;
      logic [2:0] fn;
      logic       halted;
   } ctrl_t;

   function automatic logic is_branch(input logic [3:0] op);
      return op <= OP_BR_LAST;
   endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Datapath/memory side of the control sequencer. The controller uses the
// master modport; the datapath model uses the slave modport.
interface multicycle_controller_if;
   logic [3:0] ir1;
   logic [2:0] ir2;
   logic       dcond;
   logic       mem_ready;
   logic       tmar;
   logic       ldmar;
   logic       tmdr;
   logic       ldmdr;
   logic       memwr;
   logic       memrd;
   logic       rd;
   logic       wr;
   logic       tsp;
   logic       ldsp;
   logic       tpc;
   logic       ldpc;
   logic       ldt;
   logic       tir;
   logic       ldir;
   logic       m1;
   logic       m2;
   logic [2:0] fnotsel_cont;
   logic       halted;
   logic       illegal;
   logic [4:0] state_o;

   modport master (
      input  ir1, ir2, dcond, mem_ready,
      output tmar, ldmar, tmdr, ldmdr, memwr, memrd, rd, wr, tsp, ldsp,
             tpc, ldpc, ldt, tir, ldir, m1, m2, fnotsel_cont, halted,
             illegal, state_o
   );

   modport slave (
      output ir1, ir2, dcond, mem_ready,
      input  tmar, ldmar, tmdr, ldmdr, memwr, memrd, rd, wr, tsp, ldsp,
             tpc, ldpc, ldt, tir, ldir, m1, m2, fnotsel_cont, halted,
             illegal, state_o
   );
endinterface

// File: rtl/multicycle_controller_decode.sv
// Moore output decode: maps the current state to the full datapath control
// word. The PU*/PO* decodes exist only when CTRL_STACK_EN is defined;
// otherwise tsp/ldsp are never set.
module ctrl_decode
   import cpu_ctrl_pkg::*;
(
   input  state_t state,
   input  logic   dcond,
   output ctrl_t  ctrl
);

   // One control word per state; anything not listed drives all strobes low
   always_comb begin
      ctrl = '0;
      case (state)
         S_F0:   begin ctrl.tpc  = 1'b1; ctrl.fn = FN_PASSX; ctrl.ldmar = 1'b1; end
         S_F1:   begin ctrl.tmar = 1'b1; ctrl.memrd = 1'b1;  ctrl.ldir  = 1'b1; end
         S_F2:   begin ctrl.tpc  = 1'b1; ctrl.fn = FN_INC;   ctrl.ldpc  = 1'b1; end
         S_BR0:  begin ctrl.tir  = 1'b1; ctrl.fn = FN_PASSX; ctrl.ldpc  = dcond; end
         S_ALU0: begin ctrl.rd   = 1'b1; ctrl.m1 = 1'b1;     ctrl.wr    = 1'b1; end
         S_LDT0: begin ctrl.rd   = 1'b1; ctrl.fn = FN_PASSX; ctrl.ldt   = 1'b1; end
         S_LD0:  begin ctrl.rd   = 1'b1; ctrl.fn = FN_PASSX; ctrl.ldmar = 1'b1; end
         S_LD1:  begin ctrl.tmar = 1'b1; ctrl.memrd = 1'b1;  ctrl.ldmdr = 1'b1; end
         S_LD2:  begin ctrl.tmdr = 1'b1; ctrl.fn = FN_PASSX; ctrl.wr    = 1'b1; end
         S_ST0:  begin ctrl.fn   = FN_PASSY; ctrl.ldmar = 1'b1; end
         S_ST1:  begin ctrl.rd   = 1'b1; ctrl.fn = FN_PASSX; ctrl.m2 = 1'b1; ctrl.ldmdr = 1'b1; end
         S_ST2:  begin ctrl.tmar = 1'b1; ctrl.memwr = 1'b1; end
`ifdef CTRL_STACK_EN
         S_PU0:  begin ctrl.tsp  = 1'b1; ctrl.fn = FN_DEC;   ctrl.ldsp  = 1'b1; end
         S_PU1:  begin ctrl.tsp  = 1'b1; ctrl.fn = FN_PASSX; ctrl.ldmar = 1'b1; end
         S_PU2:  begin ctrl.rd   = 1'b1; ctrl.fn = FN_PASSX; ctrl.m2 = 1'b1; ctrl.ldmdr = 1'b1; end
         S_PU3:  begin ctrl.tmar = 1'b1; ctrl.memwr = 1'b1; end
         S_PO0:  begin ctrl.tsp  = 1'b1; ctrl.fn = FN_PASSX; ctrl.ldmar = 1'b1; end
         S_PO1:  begin ctrl.tmar = 1'b1; ctrl.memrd = 1'b1;  ctrl.ldmdr = 1'b1; end
         S_PO2:  begin ctrl.tmdr = 1'b1; ctrl.fn = FN_PASSX; ctrl.wr    = 1'b1; end
         S_PO3:  begin ctrl.tsp  = 1'b1; ctrl.fn = FN_INC;   ctrl.ldsp  = 1'b1; end
`endif
         S_HALT: begin ctrl.halted = 1'b1; end
         default: ;
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// Hardwired Moore control sequencer for the multicycle CPU datapath:
// fetch, decode and execute of the 16-bit instruction set.
// Optional feature macro: CTRL_STACK_EN (PUSH/POP support). Without it,
// PUSH/POP flag illegal in DEC and execute as a NOP.
module multicycle_controller
   import cpu_ctrl_pkg::*;
#(
   parameter int SP_EN_DEFAULT = 1
)
(
   input  logic                       clk,
   input  logic                       reset,
   multicycle_controller_if.master    bus
);

   if (SP_EN_DEFAULT != 0 && SP_EN_DEFAULT != 1) begin : g_bad_sp_en
      $error("SP_EN_DEFAULT must be 0 or 1");
   end

   state_t state_q;
   state_t state_d;
   ctrl_t  ctrl;

   // State register; reset parks the sequencer in RST
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_RST;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state: linear sequencing, memory waits on mem_ready, opcode dispatch in DEC
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_RST:  state_d = S_F0;
         S_F0:   state_d = S_F1;
         S_F1:   if (bus.mem_ready) state_d = S_F2;
         S_F2:   state_d = S_DEC;
         S_DEC: begin
            if (is_branch(bus.ir1)) begin
               state_d = S_BR0;
            end else begin
               case (bus.ir1)
                  OP_ALU:   state_d = S_ALU0;
                  OP_LDT:   state_d = S_LDT0;
                  OP_LOAD:  state_d = S_LD0;
                  OP_STORE: state_d = S_ST0;
`ifdef CTRL_STACK_EN
                  OP_PUSH:  state_d = S_PU0;
                  OP_POP:   state_d = S_PO0;
`endif
                  OP_HALT:  state_d = S_HALT;
                  default:  state_d = S_F0;
               endcase
            end
         end
         S_BR0:  state_d = S_F0;
         S_ALU0: state_d = S_F0;
         S_LDT0: state_d = S_F0;
         S_LD0:  state_d = S_LD1;
         S_LD1:  if (bus.mem_ready) state_d = S_LD2;
         S_LD2:  state_d = S_F0;
         S_ST0:  state_d = S_ST1;
         S_ST1:  state_d = S_ST2;
         S_ST2:  if (bus.mem_ready) state_d = S_F0;
`ifdef CTRL_STACK_EN
         S_PU0:  state_d = S_PU1;
         S_PU1:  state_d = S_PU2;
         S_PU2:  state_d = S_PU3;
         S_PU3:  if (bus.mem_ready) state_d = S_F0;
         S_PO0:  state_d = S_PO1;
         S_PO1:  if (bus.mem_ready) state_d = S_PO2;
         S_PO2:  state_d = S_PO3;
         S_PO3:  state_d = S_F0;
`endif
         S_HALT: state_d = S_HALT;
         default: state_d = S_RST;
      endcase
   end

   ctrl_decode u_decode (
      .state (state_q),
      .dcond (bus.dcond),
      .ctrl  (ctrl)
   );

   // Load strobes and memwr are masked while reset is high so no register or
   // memory location is disturbed in the cycle reset arrives.
   assign bus.tmar         = ctrl.tmar;
   assign bus.ldmar        = ctrl.ldmar & ~reset;
   assign bus.tmdr         = ctrl.tmdr;
   assign bus.ldmdr        = ctrl.ldmdr & ~reset;
   assign bus.memwr        = ctrl.memwr & ~reset;
   assign bus.memrd        = ctrl.memrd;
   assign bus.rd           = ctrl.rd;
   assign bus.wr           = ctrl.wr;
   assign bus.tsp          = ctrl.tsp;
   assign bus.ldsp         = ctrl.ldsp & ~reset;
   assign bus.tpc          = ctrl.tpc;
   assign bus.ldpc         = ctrl.ldpc & ~reset;
   assign bus.ldt          = ctrl.ldt & ~reset;
   assign bus.tir          = ctrl.tir;
   assign bus.ldir         = ctrl.ldir & ~reset;
   assign bus.m1           = ctrl.m1;
   assign bus.m2           = ctrl.m2;
   assign bus.fnotsel_cont = ctrl.fn;
   assign bus.halted       = ctrl.halted;
   assign bus.state_o      = state_q;

`ifdef CTRL_STACK_EN
   assign bus.illegal = 1'b0;
`else
   assign bus.illegal = (state_q == S_DEC) && ((bus.ir1 == OP_PUSH) || (bus.ir1 == OP_POP));
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: each instruction is expanded into its
// expected cycle-by-cycle control words from the instruction-level transfer
// table, and the DUT is stepped through it with random waits and inputs.
module tb_multicycle_controller;
   import cpu_ctrl_pkg::*;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   multicycle_controller_if bus_if ();

   multicycle_controller #(.SP_EN_DEFAULT(1)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if)
   );

   typedef struct packed {
      logic       tmar, ldmar, tmdr, ldmdr, memwr, memrd, rd, wr, tsp, ldsp;
      logic       tpc, ldpc, ldt, tir, ldir, m1, m2;
      logic [2:0] fn;
      logic       halted, illegal;
      logic [4:0] st;
   } obs_t;

   typedef struct packed {
      obs_t e;
      logic wt;
   } step_t;

   localparam int TMAR  = 1 << 0;
   localparam int LDMAR = 1 << 1;
   localparam int TMDR  = 1 << 2;
   localparam int LDMDR = 1 << 3;
   localparam int MEMWR = 1 << 4;
   localparam int MEMRD = 1 << 5;
   localparam int RD    = 1 << 6;
   localparam int WR    = 1 << 7;
   localparam int TSP   = 1 << 8;
   localparam int LDSP  = 1 << 9;
   localparam int TPC   = 1 << 10;
   localparam int LDPC  = 1 << 11;
   localparam int LDT   = 1 << 12;
   localparam int TIR   = 1 << 13;
   localparam int LDIR  = 1 << 14;
   localparam int M1    = 1 << 15;
   localparam int M2    = 1 << 16;
   localparam int HLT   = 1 << 17;
   localparam int ILL   = 1 << 18;

   step_t plan_q[$];
   int    errors = 0;
   int    checks = 0;

   function automatic obs_t w(input int m, input logic [2:0] fn, input state_t st);
      obs_t o;
      o.tmar  = m[0];  o.ldmar = m[1];  o.tmdr  = m[2];  o.ldmdr = m[3];
      o.memwr = m[4];  o.memrd = m[5];  o.rd    = m[6];  o.wr    = m[7];
      o.tsp   = m[8];  o.ldsp  = m[9];  o.tpc   = m[10]; o.ldpc  = m[11];
      o.ldt   = m[12]; o.tir   = m[13]; o.ldir  = m[14]; o.m1    = m[15];
      o.m2    = m[16]; o.halted = m[17]; o.illegal = m[18];
      o.fn    = fn;
      o.st    = st;
      return o;
   endfunction

   function automatic obs_t sample();
      obs_t o;
      o.tmar  = bus_if.tmar;  o.ldmar = bus_if.ldmar; o.tmdr  = bus_if.tmdr;
      o.ldmdr = bus_if.ldmdr; o.memwr = bus_if.memwr; o.memrd = bus_if.memrd;
      o.rd    = bus_if.rd;    o.wr    = bus_if.wr;    o.tsp   = bus_if.tsp;
      o.ldsp  = bus_if.ldsp;  o.tpc   = bus_if.tpc;   o.ldpc  = bus_if.ldpc;
      o.ldt   = bus_if.ldt;   o.tir   = bus_if.tir;   o.ldir  = bus_if.ldir;
      o.m1    = bus_if.m1;    o.m2    = bus_if.m2;    o.fn    = bus_if.fnotsel_cont;
      o.halted = bus_if.halted; o.illegal = bus_if.illegal; o.st = bus_if.state_o;
      return o;
   endfunction

   task automatic check(input string tag, input obs_t e);
      obs_t o;
      #1;
      o = sample();
      checks++;
      assert (o === e) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, o, e);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic void push_step(input int m, input logic [2:0] fn, input state_t st, input logic wt);
      step_t s;
      s.e  = w(m, fn, st);
      s.wt = wt;
      plan_q.push_back(s);
   endfunction

   // Expected per-cycle control words for one instruction, fetch included
   function automatic void build_plan(input int op, input logic dc);
      int ill;
      ill = 0;
      plan_q.delete();
`ifndef CTRL_STACK_EN
      if (op == 13 || op == 14) ill = ILL;
`endif
      push_step(TPC | LDMAR,         3'b110, S_F0,  1'b0);
      push_step(TMAR | MEMRD | LDIR, 3'b000, S_F1,  1'b1);
      push_step(TPC | LDPC,          3'b100, S_F2,  1'b0);
      push_step(ill,                 3'b000, S_DEC, 1'b0);
      if (op <= 8) begin
         push_step(TIR | (dc ? LDPC : 0), 3'b110, S_BR0, 1'b0);
      end else begin
         case (op)
            9:  push_step(RD | M1 | WR, 3'b000, S_ALU0, 1'b0);
            10: push_step(RD | LDT,     3'b110, S_LDT0, 1'b0);
            11: begin
               push_step(RD | LDMAR,           3'b110, S_LD0, 1'b0);
               push_step(TMAR | MEMRD | LDMDR, 3'b000, S_LD1, 1'b1);
               push_step(TMDR | WR,            3'b110, S_LD2, 1'b0);
            end
            12: begin
               push_step(LDMAR,             3'b111, S_ST0, 1'b0);
               push_step(RD | M2 | LDMDR,   3'b110, S_ST1, 1'b0);
               push_step(TMAR | MEMWR,      3'b000, S_ST2, 1'b1);
            end
`ifdef CTRL_STACK_EN
            13: begin
               push_step(TSP | LDSP,        3'b101, S_PU0, 1'b0);
               push_step(TSP | LDMAR,       3'b110, S_PU1, 1'b0);
               push_step(RD | M2 | LDMDR,   3'b110, S_PU2, 1'b0);
               push_step(TMAR | MEMWR,      3'b000, S_PU3, 1'b1);
            end
            14: begin
               push_step(TSP | LDMAR,          3'b110, S_PO0, 1'b0);
               push_step(TMAR | MEMRD | LDMDR, 3'b000, S_PO1, 1'b1);
               push_step(TMDR | WR,            3'b110, S_PO2, 1'b0);
               push_step(TSP | LDSP,           3'b100, S_PO3, 1'b0);
            end
`endif
            15: for (int i = 0; i < 21; i++) push_step(HLT, 3'b000, S_HALT, 1'b0);
            default: ;
         endcase
      end
   endfunction

   task automatic do_reset(input int n);
      reset = 1'b1;
      tick();
      for (int i = 0; i < n; i++) begin
         bus_if.ir1 = 4'($urandom); bus_if.ir2 = 3'($urandom);
         bus_if.dcond = 1'($urandom); bus_if.mem_ready = 1'($urandom);
         check($sformatf("reset_hold%0d", i), w(0, 3'b000, S_RST));
         tick();
      end
      reset = 1'b0;
      check("reset_release", w(0, 3'b000, S_RST));
      tick();
   endtask

   // wf/wx: wait cycles in the fetch / execute memory state; rst_mid asserts
   // reset after the first execute wait cycle and abandons the instruction.
   task automatic run_instr(input int op, input logic dc, input int wf, input int wx, input logic rst_mid);
      step_t s;
      obs_t  g;
      int    nw;
      build_plan(op, dc);
      foreach (plan_q[k]) begin
         s = plan_q[k];
         bus_if.ir1   = (k < 2) ? 4'($urandom) : 4'(op);
         bus_if.ir2   = 3'($urandom);
         bus_if.dcond = (s.e.st == S_BR0) ? dc : 1'($urandom);
         if (s.wt) begin
            nw = (k < 4) ? wf : wx;
            for (int i = 0; i < nw; i++) begin
               bus_if.mem_ready = 1'b0;
               check($sformatf("op%0d_step%0d_wait%0d", op, k, i), s.e);
               if (rst_mid && k >= 4) begin
                  reset = 1'b1;
                  g = s.e;
                  g.memwr = 1'b0; g.ldmar = 1'b0; g.ldmdr = 1'b0; g.ldpc = 1'b0;
                  g.ldir = 1'b0;  g.ldt = 1'b0;   g.ldsp = 1'b0;
                  check("reset_in_wait", g);
                  tick();
                  reset = 1'b0;
                  check("after_reset_in_wait", w(0, 3'b000, S_RST));
                  tick();
                  return;
               end
               tick();
            end
            bus_if.mem_ready = 1'b1;
         end else begin
            bus_if.mem_ready = 1'($urandom);
         end
         check($sformatf("op%0d_step%0d", op, k), s.e);
         tick();
      end
   endtask

   initial begin
      reset = 1'b1;
      bus_if.ir1 = '0; bus_if.ir2 = '0; bus_if.dcond = 1'b0; bus_if.mem_ready = 1'b0;
      do_reset(3);
      run_instr(9, 1'b0, 2, 0, 1'b0);
      run_instr(3, 1'b0, 0, 0, 1'b0);
      run_instr(3, 1'b1, 0, 0, 1'b0);
      run_instr(11, 1'($urandom), 0, 0, 1'b0);
      run_instr(13, 1'b0, 0, 0, 1'b0);
      run_instr(14, 1'b1, 1, 2, 1'b0);
      repeat (40) begin
         run_instr(int'($urandom_range(0, 14)), 1'($urandom),
                   int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), 1'b0);
      end
      run_instr(12, 1'b0, 0, 2, 1'b1);
      run_instr(10, 1'b0, 0, 0, 1'b0);
      run_instr(15, 1'b0, 1, 0, 1'b0);
      do_reset(2);
      run_instr(0, 1'b1, 0, 0, 1'b0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "bench did not finish");
   end

endmodule
